// File: rtl/vip_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vip_mem_pkg
//  Description : Shared types and bounds for the vip_mem_responder memory
//                model: port index type and legal ranges for read latency,
//                outstanding limit and port count.
//  Revision    : 1.0 - initial release
// ============================================================================
package vip_mem_pkg;

    // Port count is bounded to 8, so a 3-bit index covers every legal build.
    localparam int c_num_ports_max       = 8;
    localparam int c_port_id_w           = 3;

    localparam int c_rd_latency_min      = 1;
    localparam int c_rd_latency_max      = 8;
    localparam int c_max_outstanding_min = 1;
    localparam int c_max_outstanding_max = 15;

    // Wide enough to hold c_max_outstanding_max.
    localparam int c_count_w             = 4;

    typedef logic [c_port_id_w-1:0] port_id_t;

endpackage : vip_mem_pkg
`default_nettype wire

// File: rtl/vip_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vip_rr_arbiter
//  Description : Round-robin single-grant arbiter. The first eligible port at
//                or after the pointer wins; the pointer then moves to the port
//                after the winner and holds when nothing is granted.
//  Ports       : clk_sys, rst_sys_n (sync, active-low)
//                i_eligible    [NUM_PORTS]  eligible requesters
//                o_grant       [NUM_PORTS]  one-hot grant (combinational)
//                o_grant_valid              any grant this cycle
//                o_grant_idx                index of the granted port
//  Revision    : 1.0 - initial release
// ============================================================================
module vip_rr_arbiter
    import vip_mem_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic                 clk_sys,
    input  logic                 rst_sys_n,
    input  logic [NUM_PORTS-1:0] i_eligible,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic                 o_grant_valid,
    output port_id_t             o_grant_idx
);

    port_id_t r_ptr;
    int       w_best_p;
    int       w_best_d;

    // Rank every eligible port by its rotational distance from the pointer
    // and keep the closest one.
    always_comb begin
        int d;
        w_best_p = 0;
        w_best_d = NUM_PORTS;
        for (int p = 0; p < NUM_PORTS; p++) begin
            d = (p + NUM_PORTS - int'(r_ptr)) % NUM_PORTS;
            if (i_eligible[p] && (d < w_best_d)) begin
                w_best_d = d;
                w_best_p = p;
            end
        end
    end

    always_comb begin
        o_grant       = '0;
        o_grant_valid = (w_best_d < NUM_PORTS);
        o_grant_idx   = port_id_t'(w_best_p);
        for (int p = 0; p < NUM_PORTS; p++) begin
            o_grant[p] = o_grant_valid && (p == w_best_p);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            r_ptr <= '0;
        end else if (o_grant_valid) begin
            r_ptr <= port_id_t'((w_best_p + 1) % NUM_PORTS);
        end
    end

endmodule : vip_rr_arbiter
`default_nettype wire

// File: rtl/vip_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : vip_mem_responder
//  Description : Multi-port OBI-style memory responder backed by one shared
//                single-ported word array. One grant per cycle (round robin),
//                fixed read latency, per-port outstanding limit, byte-enabled
//                writes. Responses return in grant order.
//  Ports       : clk_sys, rst_sys_n (sync, active-low)
//                req/gnt/rvalid/we/err [NUM_PORTS]
//                be    [NUM_PORTS*DATA_WIDTH/8]   addr [NUM_PORTS*ADDR_WIDTH]
//                wdata [NUM_PORTS*DATA_WIDTH]     rdata [NUM_PORTS*DATA_WIDTH]
//  Options     : MEM_RESP_ERR_EN - word index >= MEM_WORDS returns err=1 with
//                no array write; otherwise addresses wrap modulo MEM_WORDS
//                and err is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module vip_mem_responder
    import vip_mem_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MEM_WORDS       = 4096,
    parameter int RD_LATENCY      = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                              clk_sys,
    input  logic                              rst_sys_n,
    input  logic [NUM_PORTS-1:0]              req,
    output logic [NUM_PORTS-1:0]              gnt,
    output logic [NUM_PORTS-1:0]              rvalid,
    input  logic [NUM_PORTS-1:0]              we,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]   rdata,
    output logic [NUM_PORTS-1:0]              err
);

    localparam int c_bytes  = DATA_WIDTH / 8;
    localparam int c_offs_w = (c_bytes > 1) ? $clog2(c_bytes) : 0;
    localparam int c_idx_w  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [c_count_w-1:0] c_max_out = c_count_w'(MAX_OUTSTANDING);

    typedef struct packed {
        logic                  valid;
        port_id_t              port_id;
        logic                  err;
        logic [DATA_WIDTH-1:0] data;
    } resp_entry_t;

    logic [DATA_WIDTH-1:0] r_mem   [MEM_WORDS];
    resp_entry_t           r_pipe  [RD_LATENCY];
    logic [c_count_w-1:0]  r_count [NUM_PORTS];

    resp_entry_t            w_head;
    resp_entry_t            w_new;
    logic [NUM_PORTS-1:0]   w_elig;
    logic [NUM_PORTS-1:0]   w_grant;
    logic                   w_grant_valid;
    port_id_t               w_grant_idx;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic                   w_sel_we;
    logic [c_bytes-1:0]     w_sel_be;
    logic [DATA_WIDTH-1:0]  w_sel_wdata;
    logic [ADDR_WIDTH-1:0]  w_word_full;
    logic [c_idx_w-1:0]     w_idx;
    logic                   w_oob;
    logic [DATA_WIDTH-1:0]  w_rd_word;
    logic                   w_unused;

    assign w_head = r_pipe[RD_LATENCY-1];

    // Per-port response decode, eligibility, output gating and counters.
    // Everything visible is forced low while reset is asserted so in-flight
    // responses are never delivered.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign rvalid[p] = rst_sys_n && w_head.valid && (w_head.port_id == port_id_t'(p));
        assign err[p]    = rvalid[p] && w_head.err;
        assign rdata[p*DATA_WIDTH +: DATA_WIDTH] = rvalid[p] ? w_head.data : '0;

        // A response leaving this cycle frees a slot for a same-cycle grant.
        assign w_elig[p] = rst_sys_n && req[p] && ((r_count[p] < c_max_out) || rvalid[p]);

        always_ff @(posedge clk_sys) begin
            if (!rst_sys_n) begin
                r_count[p] <= '0;
            end else begin
                case ({w_grant[p], rvalid[p]})
                    2'b10:   r_count[p] <= r_count[p] + 1'b1;
                    2'b01:   r_count[p] <= r_count[p] - 1'b1;
                    default: r_count[p] <= r_count[p];
                endcase
            end
        end
    end

    assign gnt = w_grant;

    vip_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .clk_sys       (clk_sys),
        .rst_sys_n     (rst_sys_n),
        .i_eligible    (w_elig),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    // One-hot mux of the granted port's request fields.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_we    = 1'b0;
        w_sel_be    = '0;
        w_sel_wdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_grant[p]) begin
                w_sel_addr  = addr[p*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_we    = we[p];
                w_sel_be    = be[p*c_bytes +: c_bytes];
                w_sel_wdata = wdata[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_word_full = w_sel_addr >> c_offs_w;
    assign w_idx       = w_word_full[c_idx_w-1:0];

`ifdef MEM_RESP_ERR_EN
    assign w_oob = (w_word_full >= ADDR_WIDTH'(MEM_WORDS));
`else
    assign w_oob = 1'b0;
`endif

    // Offset bits and index bits above the array depth are intentionally
    // ignored.
    assign w_unused  = ^{w_word_full, w_sel_addr};

    assign w_rd_word = w_oob ? '0 : r_mem[w_idx];

    always_comb begin
        w_new         = '0;
        w_new.valid   = w_grant_valid;
        w_new.port_id = w_grant_idx;
        w_new.err     = w_oob;
        w_new.data    = w_sel_we ? '0 : w_rd_word;
    end

    // Array contents survive reset; only granted, in-range writes land.
    always_ff @(posedge clk_sys) begin
        if (w_grant_valid && w_sel_we && !w_oob) begin
            for (int b = 0; b < c_bytes; b++) begin
                if (w_sel_be[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_sel_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Fixed-latency response shift register; stage 0 is loaded in the grant
    // cycle, the last stage drives the outputs.
    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_new;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

endmodule : vip_mem_responder
`default_nettype wire

// File: tb/tb_vip_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vip_mem_responder
//  Description : Self-checking bench for vip_mem_responder (2 ports, read
//                latency 3, outstanding limit 2, 4096 words). A behavioural
//                model predicts gnt/rvalid/rdata/err every cycle; directed
//                sequences add literal expectations. Honours MEM_RESP_ERR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vip_mem_responder;

    localparam int c_np   = 2;
    localparam int c_lat  = 3;
    localparam int c_maxo = 2;
    localparam int c_words = 4096;

    logic        clk_sys = 1'b0;
    logic        rst_sys_n;
    logic [1:0]  req, we;
    logic [7:0]  be;
    logic [63:0] addr, wdata;
    logic [1:0]  gnt, rvalid, err;
    logic [63:0] rdata;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_sys = ~clk_sys;

    vip_mem_responder #(
        .NUM_PORTS       (c_np),
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MEM_WORDS       (c_words),
        .RD_LATENCY      (c_lat),
        .MAX_OUTSTANDING (c_maxo)
    ) dut (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .req       (req),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .we        (we),
        .be        (be),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .err       (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          port;
        int          due;
        bit          e;
        logic [31:0] d;
        bit          known;
    } resp_t;

    resp_t       m_q[$];
    logic [31:0] m_mem [int];
    int          m_cnt [2];
    int          m_ptr = 0;
    int          m_cyc = 0;

    function automatic void decode(input logic [31:0] a, output int idx, output bit oob);
        longint w;
        w = longint'(a) >> 2;
`ifdef MEM_RESP_ERR_EN
        oob = (w >= c_words);
        idx = int'(w);
`else
        oob = 1'b0;
        idx = int'(w % c_words);
`endif
    endfunction

    always @(negedge clk_sys) begin : model
        logic [1:0]  e_gnt, e_rv, e_err, elig;
        logic [63:0] e_rd;
        bit          rd_known;
        int          gp, rv_port, idx;
        bit          oob;
        resp_t       r, nr;
        e_gnt = 0; e_rv = 0; e_err = 0; e_rd = 0; rd_known = 1; rv_port = -1;
        if (!rst_sys_n) begin
            m_q.delete();
            m_cnt[0] = 0; m_cnt[1] = 0;
            m_ptr = 0;
        end else begin
            if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
                r = m_q.pop_front();
                rv_port = r.port;
                e_rv[r.port] = 1'b1;
                e_err[r.port] = r.e;
                e_rd[r.port*32 +: 32] = r.d;
                rd_known = r.known;
            end
            for (int p = 0; p < c_np; p++)
                elig[p] = req[p] && (m_cnt[p] < c_maxo || e_rv[p]);
            gp = -1;
            for (int k = 0; k < c_np; k++) begin
                if (gp < 0 && elig[(m_ptr + k) % c_np]) gp = (m_ptr + k) % c_np;
            end
            if (gp >= 0) begin
                e_gnt[gp] = 1'b1;
                decode(addr[gp*32 +: 32], idx, oob);
                nr.port = gp; nr.due = m_cyc + c_lat; nr.e = oob; nr.d = 0; nr.known = 1;
                if (we[gp]) begin
                    if (!oob) begin
                        for (int b = 0; b < 4; b++)
                            if (be[gp*4 + b]) m_mem[idx][b*8 +: 8] = wdata[gp*32 + b*8 +: 8];
                    end
                end else if (!oob) begin
                    nr.known = m_mem.exists(idx);
                    nr.d = nr.known ? m_mem[idx] : 32'h0;
                end
                m_q.push_back(nr);
                m_cnt[gp]++;
                m_ptr = (gp + 1) % c_np;
            end
            if (rv_port >= 0) m_cnt[rv_port]--;
        end
        check("gnt", gnt, e_gnt);
        check("rvalid", rvalid, e_rv);
        check("err", err, e_err);
        if (rd_known) check("rdata", rdata, e_rd);
        m_cyc++;
    end

    // ---------------- driver helpers ----------------
    task automatic set_port(input int p, input bit r, input bit w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] b);
        req[p] = r; we[p] = w;
        addr[p*32 +: 32] = a; wdata[p*32 +: 32] = d; be[p*4 +: 4] = b;
    endtask

    task automatic access(input int p, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, output logic [31:0] rd, output logic e);
        @(posedge clk_sys); #1;
        req = 0;
        set_port(p, 1, w, a, d, b);
        @(negedge clk_sys); #1;
        check($sformatf("acc_gnt_p%0d", p), gnt, 2'b01 << p);
        for (int i = 0; i < c_lat; i++) begin
            @(posedge clk_sys); #1; req = 0;
            @(negedge clk_sys); #1;
        end
        check($sformatf("acc_rvalid_p%0d", p), rvalid, 2'b01 << p);
        rd = rdata[p*32 +: 32];
        e  = err[p];
    endtask

    // Port 1 writes in cycle t, port 0 reads in cycle t+1.
    task automatic wr_rd(input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] wbe,
                         input logic [31:0] ra, output logic [31:0] rd, output logic e);
        @(posedge clk_sys); #1;
        req = 0;
        set_port(1, 1, 1, wa, wd, wbe);
        @(negedge clk_sys); #1;
        check("wr_gnt", gnt, 2'b10);
        @(posedge clk_sys); #1;
        req = 0;
        set_port(0, 1, 0, ra, 0, 0);
        @(negedge clk_sys); #1;
        check("rd_gnt", gnt, 2'b01);
        for (int i = 0; i < c_lat - 1; i++) begin
            @(posedge clk_sys); #1; req = 0;
            @(negedge clk_sys); #1;
        end
        check("wr_rvalid", rvalid, 2'b10);
        check("wr_rdata_zero", rdata[63:32], 32'h0);
        @(posedge clk_sys); #1;
        @(negedge clk_sys); #1;
        check("rd_rvalid", rvalid, 2'b01);
        rd = rdata[31:0];
        e  = err[0];
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_sys); #1; req = 0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : driver
        logic [31:0] rd;
        logic        e;
        logic [1:0]  gnt_seen;
        logic [5:0]  outst_pat;
        rst_sys_n = 0; req = 0; we = 0; be = 0; addr = 0; wdata = 0;

        // Requests during reset must not be granted.
        repeat (3) begin
            @(posedge clk_sys); #1; req = 2'b11;
            @(negedge clk_sys); #1;
            check("rst_gnt", gnt, 2'b00);
            check("rst_outputs", {rvalid, err, rdata}, 0);
        end
        @(posedge clk_sys); #1; rst_sys_n = 1; req = 0;
        repeat (10) begin
            @(negedge clk_sys); #1;
            check("idle_outputs", {gnt, rvalid, err, rdata}, 0);
            @(posedge clk_sys); #1;
        end

        // Write then read-after-write, then byte-enabled merge.
        wr_rd(32'h10, 32'hDEADBEEF, 4'hF, 32'h10, rd, e);
        check("raw_data", rd, 32'hDEADBEEF);
        check("raw_err", e, 1'b0);
        wr_rd(32'h10, 32'h11223344, 4'b0101, 32'h10, rd, e);
        check("be_merge", rd, 32'hDE22BE44);

        // Zero byte-enable write still answers and changes nothing.
        access(1, 1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, e);
        check("be0_rdata", rd, 32'h0);

`ifdef MEM_RESP_ERR_EN
        access(1, 1, 32'h4010, 32'hCAFEF00D, 4'hF, rd, e);
        check("oob_wr_err", e, 1'b1);
        check("oob_wr_rdata", rd, 32'h0);
        access(1, 0, 32'h10, 0, 0, rd, e);
        check("oob_no_alias", rd, 32'hDE22BE44);
        access(1, 0, 32'h4010, 0, 0, rd, e);
        check("oob_rd_err", e, 1'b1);
        check("oob_rd_rdata", rd, 32'h0);
`else
        access(1, 0, 32'h4010, 0, 0, rd, e);
        check("wrap_data", rd, 32'hDE22BE44);
        check("wrap_err", e, 1'b0);
`endif

        // Round robin: pointer sits at 0 after the port-1 access above.
        @(posedge clk_sys); #1;
        set_port(0, 1, 0, 32'h10, 0, 0);
        set_port(1, 1, 0, 32'h14, 0, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_sys); #1;
            check($sformatf("rr_gnt%0d", i), gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i == 3) check("rr_rvalid_lat", rvalid, 2'b01);
            @(posedge clk_sys); #1;
        end
        idle(8);

        // Outstanding limit on a single continuous requester.
        outst_pat = 6'b011011;  // bit i = expected gnt[0] in cycle i
        set_port(0, 1, 0, 32'h10, 0, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_sys); #1;
            check($sformatf("outst_gnt%0d", i), gnt[0], outst_pat[i]);
            @(posedge clk_sys); #1;
        end
        // Reset with responses still in flight: nothing may surface later.
        rst_sys_n = 0;
        @(posedge clk_sys); #1;
        @(posedge clk_sys); #1;
        rst_sys_n = 1; req = 0;
        for (int i = 0; i < c_lat + 2; i++) begin
            @(negedge clk_sys); #1;
            check("flush_rvalid", rvalid, 2'b00);
            @(posedge clk_sys); #1;
        end
        set_port(0, 1, 0, 32'h10, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_sys); #1;
            check("post_rst_gnt", gnt, 2'b01);
            @(posedge clk_sys); #1;
        end
        idle(8);

        // Initialise a small window so random reads are predictable.
        for (int i = 0; i < 16; i++)
            access(0, 1, i * 4, $urandom, 4'hF, rd, e);

        // Randomised traffic with occasional resets.
        gnt_seen = 0;
        for (int c = 0; c < 800; c++) begin
            @(posedge clk_sys); #1;
            rst_sys_n = ($urandom_range(0, 99) != 0);
            for (int p = 0; p < c_np; p++) begin
                if (!req[p] || gnt_seen[p]) begin
                    int w;
                    logic [31:0] a;
                    w = $urandom_range(0, 15);
                    a = (($urandom_range(0, 7) == 0) ? 32'h4000 : 32'h0) + w * 4 + $urandom_range(0, 3);
                    set_port(p, $urandom_range(0, 2) != 0, $urandom_range(0, 9) < 3, a,
                             $urandom, 4'($urandom_range(0, 15)));
                end
            end
            @(negedge clk_sys); #1;
            gnt_seen = gnt;
        end
        @(posedge clk_sys); #1;
        rst_sys_n = 1; req = 0;
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_vip_mem_responder
`default_nettype wire
